// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM encoding,
// derived-size helpers and the legal operand-width rule.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int digits(input int width);
    return width / 2;
  endfunction

  // idx enumerates every (i, j) digit pair, so it needs log2(D*D) bits
  function automatic int cnt_width(input int width);
    return $clog2((width / 2) * (width / 2));
  endfunction

  function automatic bit width_is_legal(input int width);
    return (width == 4) || (width == 8) || (width == 16) || (width == 32);
  endfunction

endpackage

// File: rtl/vedic_pp_2x2.sv
// 2x2-bit unsigned Vedic multiplier core (vertical and crosswise):
// AND terms for the digit products, two half adders to fold the cross terms.
module vedic_pp_2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] pp
);

  logic cross_a;
  logic cross_b;
  logic high;
  logic sum1;
  logic carry1;
  logic sum2;
  logic carry2;

  assign cross_a = x[1] & y[0];
  assign cross_b = x[0] & y[1];
  assign high    = x[1] & y[1];

  assign sum1   = cross_a ^ cross_b;
  assign carry1 = cross_a & cross_b;

  assign sum2   = high ^ carry1;
  assign carry2 = high & carry1;

  assign pp = {carry2, sum2, sum1, x[0] & y[0]};

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one 2x2 Vedic core is reused
// for every digit pair, accumulating one shifted partial product per cycle.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int D     = digits(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int HALF  = CNT_W / 2;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(D * D - 1);

  if (!width_is_legal(WIDTH)) begin : g_width_check
    $error("vedic_mul_seq: WIDTH must be one of 4, 8, 16, 32");
  end

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              out_valid_q, out_valid_d;

  logic [HALF-1:0]   dig_i;
  logic [HALF-1:0]   dig_j;
  logic [HALF:0]     a_lsb;
  logic [HALF:0]     b_lsb;
  logic [1:0]        a_dig;
  logic [1:0]        b_dig;
  logic [3:0]        pp;
  logic [HALF:0]     dig_sum;
  logic [PW-1:0]     pp_shifted;

  // Upper half of idx walks the multiplicand digits, lower half the multiplier digits
  always_comb begin
    dig_i      = idx_q[CNT_W-1:HALF];
    dig_j      = idx_q[HALF-1:0];
    a_lsb      = {dig_i, 1'b0};
    b_lsb      = {dig_j, 1'b0};
    a_dig      = 2'(a_q >> a_lsb);
    b_dig      = 2'(b_q >> b_lsb);
    dig_sum    = {1'b0, dig_i} + {1'b0, dig_j};
    pp_shifted = {{(PW-4){1'b0}}, pp} << {dig_sum, 1'b0};
  end

  vedic_pp_2x2 u_pp (
    .x  (a_dig),
    .y  (b_dig),
    .pp (pp)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_shifted;
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // acc is kept so p stays at the last product while idle
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign p         = acc_q;

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Bench for vedic_mul_seq: directed vectors on an 8-bit instance plus random
// sweeps on 4- and 16-bit instances, all checked against a per-lane product model.
module tb_vedic_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid8;
  logic        out_ready8;
  logic        in_ready8;
  logic        out_valid8;
  logic        busy8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;

  int checks          = 0;
  int errors          = 0;
  int cyc             = 0;
  int acc_cyc         = 0;
  int sweeps_finished = 0;
  bit sweep_go        = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int limit);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event not seen, required within %0d cycles", name, limit);
  endtask

  // Each lane: a DUT plus a model that only knows "a product is pending and
  // becomes visible D*D cycles after it was accepted, until it is taken".
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int W      = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    localparam int DD     = (W / 2) * (W / 2);
    localparam int NPAIRS = (g == 1) ? 1000 : 300;

    logic           l_in_valid;
    logic           l_out_ready;
    logic           l_in_ready;
    logic           l_out_valid;
    logic           l_busy;
    logic [W-1:0]   l_a;
    logic [W-1:0]   l_b;
    logic [2*W-1:0] l_p;

    vedic_mul_seq #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (l_in_valid),
      .in_ready  (l_in_ready),
      .a         (l_a),
      .b         (l_b),
      .out_valid (l_out_valid),
      .out_ready (l_out_ready),
      .p         (l_p),
      .busy      (l_busy)
    );

    bit          pend  = 1'b0;
    int          cnt   = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [63:0] exp_p = '0;
    bit          s_rst = 1'b0;
    bit          s_acc = 1'b0;
    bit          s_ohs = 1'b0;
    logic [63:0] s_prod = '0;

    always @(negedge clk) begin
      bit ev;
      ev = pend && (cnt >= DD);
      checkValue($sformatf("w%0d out_valid", W), 64'(l_out_valid), 64'(ev));
      checkValue($sformatf("w%0d in_ready", W), 64'(l_in_ready), 64'(!pend));
      checkValue($sformatf("w%0d busy", W), 64'(l_busy), 64'(pend));
      if (ev) checkValue($sformatf("w%0d p", W), 64'(l_p), exp_p);
      s_rst  = rst;
      s_acc  = l_in_valid && !pend;
      s_ohs  = ev && l_out_ready;
      s_prod = 64'(l_a) * 64'(l_b);
    end

    always @(posedge clk) begin
      if (s_rst) begin
        pend = 1'b0;
        cnt  = 0;
      end else if (s_acc) begin
        pend  = 1'b1;
        cnt   = 0;
        exp_p = s_prod;
        n_acc++;
      end else if (pend) begin
        if (s_ohs) begin
          pend = 1'b0;
          n_out++;
        end else if (cnt < DD) begin
          cnt++;
        end
      end
    end

    if (g == 0) begin : g_dir
      assign l_in_valid  = in_valid8;
      assign l_out_ready = out_ready8;
      assign l_a         = a8;
      assign l_b         = b8;
      assign in_ready8   = l_in_ready;
      assign out_valid8  = l_out_valid;
      assign busy8       = l_busy;
      assign p8          = l_p;
    end else begin : g_rnd
      initial begin
        bit drv_end;
        drv_end     = 1'b0;
        l_in_valid  = 1'b0;
        l_out_ready = 1'b1;
        l_a         = '0;
        l_b         = '0;
        wait (sweep_go);
        fork
          begin
            for (int k = 0; k < NPAIRS; k++) begin
              int gap;
              int t;
              gap = $urandom_range(0, 3);
              repeat (gap) @(posedge clk);
              #1;
              if (k == 0) begin
                l_a = '1;
                l_b = '1;
              end else if (k == 1) begin
                l_a = '0;
                l_b = W'($urandom);
              end else begin
                l_a = W'($urandom);
                l_b = W'($urandom);
              end
              l_in_valid = 1'b1;
              t = 0;
              @(negedge clk);
              while (!l_in_ready && t < 4 * DD + 8) begin
                @(negedge clk);
                t++;
              end
              if (!l_in_ready) failNow($sformatf("w%0d accept", W), 4 * DD + 8);
              @(posedge clk);
              #1;
              l_in_valid = 1'b0;
            end
            begin
              int t;
              t = 0;
              while (n_out != n_acc && t < 10 * DD + 100) begin
                @(posedge clk);
                t++;
              end
            end
            checkValue($sformatf("w%0d accepted count", W), 64'(n_acc), 64'(NPAIRS));
            checkValue($sformatf("w%0d delivered count", W), 64'(n_out), 64'(NPAIRS));
            drv_end = 1'b1;
          end
          begin
            while (!drv_end) begin
              @(posedge clk);
              #1;
              l_out_ready = ($urandom_range(0, 3) != 0);
            end
          end
        join
        l_out_ready = 1'b1;
        sweeps_finished++;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tbv);
    int t;
    a8        = ta;
    b8        = tbv;
    in_valid8 = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready8) failNow("accept", 100);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Waits for the product, checks latency and value, optionally stalls the
  // consumer for `hold` cycles, then completes the handshake.
  task automatic checkOutput(input string name, input logic [15:0] exp, input int hold);
    int t;
    out_ready8 = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!out_valid8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid8) begin
      failNow({name, " out_valid"}, 100);
      out_ready8 = 1'b1;
    end else begin
      checkValue({name, " latency"}, 64'(cyc - acc_cyc), 64'd16);
      checkValue({name, " p"}, 64'(p8), 64'(exp));
      repeat (hold) begin
        @(negedge clk);
        checkValue({name, " held out_valid"}, 64'(out_valid8), 64'd1);
        checkValue({name, " held p"}, 64'(p8), 64'(exp));
        checkValue({name, " held in_ready"}, 64'(in_ready8), 64'd0);
      end
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkValue({name, " in_ready after"}, 64'(in_ready8), 64'd1);
      checkValue({name, " out_valid after"}, 64'(out_valid8), 64'd0);
    end
  endtask

  initial begin
    int t;
    rst        = 1'b1;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    a8         = '0;
    b8         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkValue("reset in_ready", 64'(in_ready8), 64'd1);
    checkValue("reset out_valid", 64'(out_valid8), 64'd0);
    checkValue("reset busy", 64'(busy8), 64'd0);
    checkValue("reset p", 64'(p8), 64'd0);

    applyStimulus(8'h0D, 8'h0B);
    checkOutput("0d*0b", 16'h008F, 0);
    applyStimulus(8'hFF, 8'hFF);
    checkOutput("ff*ff", 16'hFE01, 0);
    applyStimulus(8'h00, 8'hAB);
    checkOutput("00*ab", 16'h0000, 0);

    applyStimulus(8'h80, 8'h02);
    checkOutput("80*02 stalled", 16'h0100, 5);

    // Second operand stays offered through CALC and DONE; only IDLE takes it
    applyStimulus(8'h12, 8'h34);
    a8        = 8'h55;
    in_valid8 = 1'b1;
    checkOutput("12*34 gated", 16'h03A8, 0);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    acc_cyc   = cyc;
    checkOutput("55*34 late", 16'h1144, 0);

    applyStimulus(8'h77, 8'h99);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkValue("abort out_valid", 64'(out_valid8), 64'd0);
    checkValue("abort busy", 64'(busy8), 64'd0);
    checkValue("abort in_ready", 64'(in_ready8), 64'd1);
    applyStimulus(8'h03, 8'h03);
    checkOutput("03*03 after abort", 16'h0009, 0);

    sweep_go = 1'b1;
    t = 0;
    while (sweeps_finished < 2 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (sweeps_finished < 2) failNow("random sweeps", 60000);

    $display("[TB] directed and random phases complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
